// File: rtl/blockmem2p_rdstream.sv
// blockmem2p_rdstream: streams a contiguous blockmem2p port-B address range out as a valid/ready burst.
// Optional feature macro BLOCKMEM_RD_WRAP_EN: addresses wrap at G_MEMDEPTH and err stays low.
module blockmem2p_rdstream #(
    parameter int G_MEMWIDTH  = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_RDLATENCY = 1,
    localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    localparam int G_LENWIDTH  = G_ADDRWIDTH + 1
) (
    input  logic                   clkb,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [G_ADDRWIDTH-1:0] base_addr,
    input  logic [G_LENWIDTH-1:0]  length,
    output logic                   enb,
    output logic [G_ADDRWIDTH-1:0] addrb,
    input  logic [G_MEMWIDTH-1:0]  doutb,
    output logic [G_MEMWIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int G_FIFODEPTH = G_RDLATENCY + 2;
    localparam int PW = $clog2(G_FIFODEPTH);
    localparam int CW = $clog2(G_FIFODEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_q;
    logic [G_ADDRWIDTH-1:0] addrb_q, nxt_q, nxt_d;
    logic [G_LENWIDTH-1:0]  len_q, iss_q, beat_q;
    logic                   enb_q, busy_q, done_q, err_q;
    logic [G_RDLATENCY-1:0] sr_q;
    logic [G_MEMWIDTH-1:0]  fifo_q [G_FIFODEPTH];
    logic [PW-1:0]          wp_q, rp_q;
    logic [CW-1:0]          cnt_q;
    logic                   enb_d, push, pop, last_beat, bad;
    int                     owed;

`ifdef BLOCKMEM_RD_WRAP_EN
    assign bad = 1'b0;
`else
    assign bad = ({2'b0, base_addr} >= (G_LENWIDTH+1)'(G_MEMDEPTH)) ||
                 ({2'b0, base_addr} + {1'b0, length} > (G_LENWIDTH+1)'(G_MEMDEPTH));
`endif

    // Every issued read owns a FIFO slot until popped; a slot freed by this cycle's pop may be reused.
    always_comb begin
        push      = sr_q[G_RDLATENCY-1];
        pop       = (cnt_q != '0) && m_tready;
        owed      = int'(cnt_q) + int'(enb_q) + $countones(sr_q) - int'(pop);
        enb_d     = (state_q == ISSUE) && (owed < G_FIFODEPTH);
        nxt_d     = (nxt_q == G_ADDRWIDTH'(G_MEMDEPTH - 1)) ? '0 : nxt_q + 1'b1;
        last_beat = pop && (beat_q == len_q - 1'b1);
    end

    always_ff @(posedge clkb or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addrb_q <= '0;
            nxt_q   <= '0;
            len_q   <= '0;
            iss_q   <= '0;
            beat_q  <= '0;
            enb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sr_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            enb_q  <= enb_d;
            sr_q   <= (sr_q << 1) | G_RDLATENCY'(enb_q);
            cnt_q  <= cnt_q + CW'(push) - CW'(pop);
            if (enb_d) begin
                addrb_q <= nxt_q;
                nxt_q   <= nxt_d;
                iss_q   <= iss_q - 1'b1;
            end
            if (push) wp_q <= (wp_q == PW'(G_FIFODEPTH - 1)) ? '0 : wp_q + 1'b1;
            if (pop) begin
                rp_q   <= (rp_q == PW'(G_FIFODEPTH - 1)) ? '0 : rp_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end
            case (state_q)
                IDLE: if (start) begin
                    if (bad) err_q <= 1'b1;
                    else if (length == '0) done_q <= 1'b1;
                    else begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        len_q   <= length;
                        iss_q   <= length;
                        nxt_q   <= base_addr;
                        beat_q  <= '0;
                    end
                end
                ISSUE: if (enb_d && iss_q == G_LENWIDTH'(1)) state_q <= DRAIN;
                DRAIN: if (last_beat) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clkb) if (push) fifo_q[wp_q] <= doutb;

    assign enb      = enb_q;
    assign addrb    = addrb_q;
    assign m_tvalid = cnt_q != '0;
    assign m_tdata  = m_tvalid ? fifo_q[rp_q] : '0;
    assign m_tlast  = m_tvalid && (beat_q == len_q - 1'b1);
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_blockmem2p_rdstream.sv
// tb_blockmem2p_rdstream: directed and random transfers scored against a word-list model of the memory.
module tb_blockmem2p_rdstream;
    localparam int W = 32, D = 1024, L = 1, FD = L + 2, AW = 10, LW = 11;

    logic clkb = 1'b0, resetn = 1'b0, start = 1'b0, m_tready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic enb, m_tvalid, m_tlast, busy, done, err;
    logic [AW-1:0] addrb;
    logic [W-1:0] doutb, m_tdata;
    logic [W-1:0] mem [D];
    logic [W-1:0] pipe [L];

    int n_cmp = 0, n_bad = 0;
    int j, first_v, last_b, done_j, n_done, n_err, n_beat, n_busy, issued, accepted;
    bit stalled;
    logic [W-1:0] hold_d;
    logic hold_l;
    logic [W:0] exp_q [$];
    logic [AW-1:0] exp_a [$];

    blockmem2p_rdstream #(.G_MEMWIDTH(W), .G_MEMDEPTH(D), .G_RDLATENCY(L)) dut (
        .clkb(clkb), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
        .enb(enb), .addrb(addrb), .doutb(doutb), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done), .err(err)
    );

    always #5 clkb = ~clkb;

    // Port-B memory: data appears L cycles after the enb cycle.
    always @(posedge clkb) begin
        if (enb) pipe[0] <= mem[addrb];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign doutb = pipe[L-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input bit rdy);
        logic [W:0] e;
        m_tready = rdy;
        @(negedge clkb);
        j++;
        if (stalled) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, hold_d);
            chk("hold_last", m_tlast, hold_l);
        end
        if (enb) begin
            issued++;
            chk("outstanding_le_fd", issued - accepted <= FD, 1);
            if (exp_a.size() > 0) chk("addrb", addrb, exp_a.pop_front());
            else chk("spurious_enb", enb, 0);
        end
        if (m_tvalid && first_v < 0) first_v = j;
        if (m_tvalid && rdy) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tdata", m_tdata, e[W-1:0]);
                chk("tlast", m_tlast, e[W]);
            end else chk("extra_beat", m_tvalid, 0);
            n_beat++;
            accepted++;
            last_b = j;
        end
        if (done) begin
            n_done++;
            done_j = j;
            chk("busy_at_done", busy, 0);
        end
        if (err) n_err++;
        if (busy) n_busy++;
        stalled = m_tvalid && !rdy;
        hold_d = m_tdata;
        hold_l = m_tlast;
        @(posedge clkb);
        #1;
    endtask

    task automatic prep(input int base, input int len);
        exp_q.delete();
        exp_a.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({i == len - 1, mem[(base + i) % D]});
            exp_a.push_back(AW'((base + i) % D));
        end
        first_v = -1; last_b = -1; done_j = -1;
        n_done = 0; n_err = 0; n_beat = 0; n_busy = 0; issued = 0; accepted = 0; stalled = 0;
        base_addr = AW'(base);
        length = LW'(len);
        start = 1'b1;
        cyc(1'b1);
        start = 1'b0;
        j = 0;
    endtask

    task automatic xfer(input int base, input int len, input int mode, input bit poke);
        prep(base, len);
        for (int k = 0; k < 4 * len + 40 && n_done == 0; k++) begin
            if (poke && j == 2) begin
                start = 1'b1;
                base_addr = AW'(base + 5);
                length = LW'(3);
            end else start = 1'b0;
            cyc(mode == 0 ? 1'b1 : mode == 1 ? ((j % 4) == 0 || (j % 4) == 3) : 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b1);
        chk("single_done", n_done, 1);
        chk("beat_count", n_beat, len);
        chk("beats_left", exp_q.size(), 0);
        chk("enb_count", issued, len);
        chk("no_err", n_err, 0);
        chk("done_after_last", done_j, len == 0 ? 1 : last_b + 1);
        chk("busy_cycles", n_busy, len == 0 ? 0 : done_j - 1);
        if (mode == 0 && len > 0) begin
            chk("first_valid", first_v, 3 + L);
            chk("back_to_back", last_b - first_v, len - 1);
        end
    endtask

    task automatic reject(input int base, input int len);
        prep(base, len);
        for (int k = 0; k < 8; k++) cyc(1'b1);
        chk("rej_err_pulse", n_err, 1);
        chk("rej_no_enb", issued, 0);
        chk("rej_no_done", n_done, 0);
        chk("rej_no_busy", n_busy, 0);
        chk("rej_no_beat", n_beat, 0);
    endtask

    initial begin
        int b, n;
        for (int i = 0; i < D; i++) mem[i] = $urandom;
        @(negedge clkb);
        @(negedge clkb);
        chk("reset_outputs", {enb, addrb, m_tvalid, m_tdata, m_tlast, busy, done, err}, 0);
        @(posedge clkb);
        #1;
        resetn = 1'b1;
        cyc(1'b1);

        xfer(16, 4, 0, 0);
        xfer(16, 4, 1, 0);
        xfer(0, 0, 0, 0);
`ifdef BLOCKMEM_RD_WRAP_EN
        xfer(D - 2, 4, 0, 0);
        xfer(1000, 40, 2, 0);
`else
        reject(D - 2, 4);
        reject(1000, 25);
`endif
        xfer(1000, 24, 0, 0);

        prep(0, 8);
        for (int k = 0; k < 20 && n_beat < 2; k++) cyc(1'b1);
        chk("beats_before_reset", n_beat, 2);
        resetn = 1'b0;
        @(negedge clkb);
        chk("midreset_outputs", {enb, addrb, m_tvalid, m_tdata, m_tlast, busy, done, err}, 0);
        @(posedge clkb);
        #1;
        resetn = 1'b1;
        stalled = 0;
        xfer(0, 2, 0, 0);

        xfer(100, 6, 0, 1);
        xfer(0, D, 0, 0);
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 20);
            b = $urandom_range(0, D - n);
            xfer(b, n, 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
